// File: rtl/inmux_sched_3_pkg.sv
// inmux_pkg: burst-length width, mux select codes, requester indices, scheduler state enum and index-to-code helper
package inmux_pkg;
  localparam int LEN_W = 8;
  localparam logic [3:0] SEL_IDLE = 4'd0;
  localparam logic [3:0] SEL_K1 = 4'd1;
  localparam logic [3:0] SEL_K13 = 4'd5;
  localparam logic [3:0] SEL_K15 = 4'd7;
  localparam logic [1:0] REQ_K1 = 2'd0;
  localparam logic [1:0] REQ_K13 = 2'd1;
  localparam logic [1:0] REQ_K15 = 2'd2;
  typedef enum logic {IDLE, BURST} state_t;
  function automatic logic [3:0] sel_code(input logic [1:0] idx);
    return idx == REQ_K1 ? SEL_K1 : idx == REQ_K13 ? SEL_K13 : idx == REQ_K15 ? SEL_K15 : SEL_IDLE;
  endfunction
endpackage

// File: rtl/inmux_sched_3_if.sv
// inmux_sched_3_if: scheduler bus; master = scheduler (in: req, req_len0..2, mux_rdy; out: t_c_dat, mux_vld, gnt, beat_ack, burst_done, busy), slave = sources/consumer side
interface inmux_sched_3_if;
  import inmux_pkg::*;
  logic [2:0] req;
  logic [LEN_W-1:0] req_len0, req_len1, req_len2;
  logic mux_rdy;
  logic [3:0] t_c_dat;
  logic mux_vld;
  logic [2:0] gnt;
  logic [2:0] beat_ack;
  logic burst_done;
  logic busy;
  modport master (
    input req, req_len0, req_len1, req_len2, mux_rdy,
    output t_c_dat, mux_vld, gnt, beat_ack, burst_done, busy
  );
  modport slave (
    output req, req_len0, req_len1, req_len2, mux_rdy,
    input t_c_dat, mux_vld, gnt, beat_ack, burst_done, busy
  );
endinterface

// File: rtl/inmux_sched_3_rr_pick3.sv
// rr_pick3: combinational 3-way round-robin picker; in req[2:0], ptr[1:0] (highest priority); out one-hot win, win index idx, any
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] win,
  output logic [1:0] idx,
  output logic       any
);
  logic [2:0] c;
  always_comb begin
    idx = 2'd0;
    any = 1'b0;
    c = 3'd0;
    for (int i = 2; i >= 0; i--) begin
      c = {1'b0, ptr == 2'd3 ? 2'd0 : ptr} + 3'(i);
      c = c >= 3'd3 ? c - 3'd3 : c;
      if (req[c[1:0]]) begin
        idx = c[1:0];
        any = 1'b1;
      end
    end
    win = any ? 3'b001 << idx : 3'b000;
  end
endmodule

// File: rtl/inmux_sched_3.sv
// inmux_sched_3: round-robin burst scheduler for the 3-source mux; ports clk, reset_n (async active-low), bus (inmux_sched_3_if.master: req/lengths/mux_rdy in, select code/valid/grant/acks out)
module inmux_sched_3
  import inmux_pkg::*;
(
  input logic clk,
  input logic reset_n,
  inmux_sched_3_if.master bus
);
  state_t state_q, state_d;
  logic [2:0] gnt_q, gnt_d, win;
  logic [3:0] sel_q, sel_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, win_len;
  logic [1:0] ptr_q, ptr_d, idx;
  logic any, beat, last;
  rr_pick3 u_pick (.req(bus.req), .ptr(ptr_q), .win(win), .idx(idx), .any(any));
  always_comb begin
    beat = state_q == BURST && bus.mux_rdy;
    last = beat && cnt_q == '0;
    win_len = idx == REQ_K1 ? bus.req_len0 : idx == REQ_K13 ? bus.req_len1 : bus.req_len2;
    state_d = state_q;
    gnt_d = gnt_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    if (state_q == IDLE || last) begin
      state_d = any ? BURST : IDLE;
      gnt_d = win;
      sel_d = any ? sel_code(idx) : SEL_IDLE;
      cnt_d = (!any || win_len == '0) ? '0 : win_len - LEN_W'(1);
      ptr_d = any ? (idx == 2'd2 ? 2'd0 : idx + 2'd1) : ptr_q;
    end else if (beat) begin
      cnt_d = cnt_q - LEN_W'(1);
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q <= 3'b000;
      sel_q <= SEL_IDLE;
      cnt_q <= '0;
      ptr_q <= 2'd0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
    end
  end
  assign bus.t_c_dat = sel_q;
  assign bus.mux_vld = state_q == BURST;
  assign bus.busy = state_q == BURST;
  assign bus.gnt = gnt_q;
  assign bus.beat_ack = gnt_q & {3{beat}};
  assign bus.burst_done = last;
endmodule

// File: tb/tb_inmux_sched_3.sv
// tb_inmux_sched_3: directed self-checking bench for inmux_sched_3
module tb_inmux_sched_3;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  inmux_sched_3_if bus();
  inmux_sched_3 dut (.clk(clk), .reset_n(reset_n), .bus(bus.master));
  always #5 clk = ~clk;
  function automatic logic [12:0] obs();
    return {bus.gnt, bus.t_c_dat, bus.mux_vld, bus.busy, bus.beat_ack, bus.burst_done};
  endfunction
  function automatic logic [12:0] ex(input logic [2:0] g, input logic [2:0] ack, input logic done);
    logic [3:0] c;
    c = g == 3'b001 ? 4'd1 : g == 3'b010 ? 4'd5 : g == 3'b100 ? 4'd7 : 4'd0;
    return {g, c, |g, |g, ack, done};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    bus.req = 3'b000;
    bus.req_len0 = '0;
    bus.req_len1 = '0;
    bus.req_len2 = '0;
    bus.mux_rdy = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask
  task automatic test_reset();
    do_reset();
    #1;
    n_chk++;
    if (obs() !== ex(3'b000, 3'b000, 1'b0)) begin
      n_fail++;
      $display("FAIL reset_idle: got %h want %h", obs(), ex(3'b000, 3'b000, 1'b0));
    end
    step();
    bus.mux_rdy = 1'b1;
    #1;
    n_chk++;
    if (obs() !== ex(3'b000, 3'b000, 1'b0)) begin
      n_fail++;
      $display("FAIL idle_rdy: got %h want %h", obs(), ex(3'b000, 3'b000, 1'b0));
    end
  endtask
  task automatic test_single();
    do_reset();
    bus.req = 3'b010;
    bus.req_len1 = 8'd3;
    bus.mux_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      bus.req = 3'b000;
      #1;
      n_chk++;
      if (obs() !== ex(3'b010, 3'b010, k == 2)) begin
        n_fail++;
        $display("FAIL single_beat%0d: got %h want %h", k, obs(), ex(3'b010, 3'b010, k == 2));
      end
    end
    step();
    #1;
    n_chk++;
    if (obs() !== ex(3'b000, 3'b000, 1'b0)) begin
      n_fail++;
      $display("FAIL single_idle: got %h want %h", obs(), ex(3'b000, 3'b000, 1'b0));
    end
  endtask
  task automatic test_back_to_back();
    logic [2:0] g;
    do_reset();
    bus.req = 3'b111;
    bus.req_len0 = 8'd1;
    bus.req_len1 = 8'd1;
    bus.req_len2 = 8'd1;
    bus.mux_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 5) bus.req = 3'b000;
      #1;
      g = 3'b001 << (k % 3);
      n_chk++;
      if (obs() !== ex(g, g, 1'b1)) begin
        n_fail++;
        $display("FAIL b2b_burst%0d: got %h want %h", k, obs(), ex(g, g, 1'b1));
      end
    end
    step();
    #1;
    n_chk++;
    if (obs() !== ex(3'b000, 3'b000, 1'b0)) begin
      n_fail++;
      $display("FAIL b2b_idle: got %h want %h", obs(), ex(3'b000, 3'b000, 1'b0));
    end
  endtask
  task automatic test_backpressure();
    logic [3:0] pat;
    pat = 4'b1001;
    do_reset();
    bus.req = 3'b100;
    bus.req_len2 = 8'd2;
    for (int k = 0; k < 4; k++) begin
      step();
      bus.req = 3'b000;
      bus.mux_rdy = pat[k];
      #1;
      n_chk++;
      if (obs() !== ex(3'b100, pat[k] ? 3'b100 : 3'b000, k == 3)) begin
        n_fail++;
        $display("FAIL bp_cycle%0d: got %h want %h", k, obs(), ex(3'b100, pat[k] ? 3'b100 : 3'b000, k == 3));
      end
    end
    step();
    #1;
    n_chk++;
    if (obs() !== ex(3'b000, 3'b000, 1'b0)) begin
      n_fail++;
      $display("FAIL bp_idle: got %h want %h", obs(), ex(3'b000, 3'b000, 1'b0));
    end
  endtask
  task automatic test_len0();
    do_reset();
    bus.req = 3'b001;
    bus.req_len0 = 8'd0;
    bus.mux_rdy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      if (k == 1) bus.req = 3'b000;
      #1;
      n_chk++;
      if (obs() !== ex(3'b001, 3'b001, 1'b1)) begin
        n_fail++;
        $display("FAIL len0_burst%0d: got %h want %h", k, obs(), ex(3'b001, 3'b001, 1'b1));
      end
    end
    step();
    #1;
    n_chk++;
    if (obs() !== ex(3'b000, 3'b000, 1'b0)) begin
      n_fail++;
      $display("FAIL len0_idle: got %h want %h", obs(), ex(3'b000, 3'b000, 1'b0));
    end
  endtask
  task automatic test_len255();
    int beats;
    int dones;
    beats = 0;
    dones = 0;
    do_reset();
    bus.req = 3'b001;
    bus.req_len0 = 8'd255;
    bus.mux_rdy = 1'b1;
    step();
    bus.req = 3'b000;
    bus.req_len0 = 8'd5;
    #1;
    for (int k = 0; k < 300; k++) begin
      if (!bus.busy) break;
      beats += int'(bus.beat_ack[0]);
      dones += int'(bus.burst_done);
      step();
      #1;
    end
    n_chk++;
    if (beats !== 255) begin
      n_fail++;
      $display("FAIL len255_beats: got %0d want 255", beats);
    end
    n_chk++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL len255_done: got %0d want 1", dones);
    end
    n_chk++;
    if (obs() !== ex(3'b000, 3'b000, 1'b0)) begin
      n_fail++;
      $display("FAIL len255_idle: got %h want %h", obs(), ex(3'b000, 3'b000, 1'b0));
    end
  endtask
  task automatic test_fairness();
    logic [2:0] fexp [6];
    fexp = '{3'b001, 3'b100, 3'b001, 3'b100, 3'b001, 3'b010};
    do_reset();
    bus.req = 3'b101;
    bus.req_len0 = 8'd1;
    bus.req_len1 = 8'd1;
    bus.req_len2 = 8'd1;
    bus.mux_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 3) bus.req = 3'b111;
      if (k == 5) bus.req = 3'b000;
      #1;
      n_chk++;
      if (obs() !== ex(fexp[k], fexp[k], 1'b1)) begin
        n_fail++;
        $display("FAIL fair_burst%0d: got %h want %h", k, obs(), ex(fexp[k], fexp[k], 1'b1));
      end
    end
    step();
    #1;
    n_chk++;
    if (obs() !== ex(3'b000, 3'b000, 1'b0)) begin
      n_fail++;
      $display("FAIL fair_idle: got %h want %h", obs(), ex(3'b000, 3'b000, 1'b0));
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    bus.req = 3'b001;
    bus.req_len0 = 8'd9;
    bus.mux_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      bus.req = 3'b000;
    end
    #1;
    n_chk++;
    if (obs() !== ex(3'b001, 3'b001, 1'b0)) begin
      n_fail++;
      $display("FAIL pre_reset: got %h want %h", obs(), ex(3'b001, 3'b001, 1'b0));
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (obs() !== ex(3'b000, 3'b000, 1'b0)) begin
      n_fail++;
      $display("FAIL async_reset: got %h want %h", obs(), ex(3'b000, 3'b000, 1'b0));
    end
    bus.req = 3'b111;
    step();
    reset_n = 1'b1;
    step();
    #1;
    n_chk++;
    if (obs() !== ex(3'b001, 3'b001, 1'b0)) begin
      n_fail++;
      $display("FAIL post_reset_prio: got %h want %h", obs(), ex(3'b001, 3'b001, 1'b0));
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_len0();
    test_len255();
    test_fairness();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/inmux_sched_3.md
Name: inmux_sched_3

Overview:
- Round-robin burst scheduler for the 3-source 512-bit input mux. Requester 0 drives the k1 source, requester 1 drives k13, requester 2 drives k15.
- Arbitrates among the three requesters and drives the mux select code t_c_dat.
- Holds each grant for a requested number of beats under a valid/ready handshake with the consumer downstream of the mux.
- Sits between the three source producers and the mux/consumer pair.

Parameters:
- LEN_W, 8, width of per-requester burst-length field
- SEL_K1, 4'd1, mux code for requester 0 (k1)
- SEL_K13, 4'd5, mux code for requester 1 (k13)
- SEL_K15, 4'd7, mux code for requester 2 (k15)
- SEL_IDLE, 4'd0, mux code driven when no grant is active

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- req  in  3  per-requester burst request, level
- req_len0  in  LEN_W  burst beats for requester 0; 0 means 1 beat
- req_len1  in  LEN_W  same, requester 1
- req_len2  in  LEN_W  same, requester 2
- mux_rdy  in  1  consumer accepts the current mux beat
- t_c_dat  out  4  select code to the mux
- mux_vld  out  1  current mux output is a valid beat
- gnt  out  3  one-hot grant, registered
- beat_ack  out  3  per-requester beat accepted (gnt & {3{mux_vld & mux_rdy}}), combinational
- burst_done  out  1  last beat of the current burst accepted this cycle, combinational
- busy  out  1  a grant is active

Behaviour:
- Reset, asynchronous, reset_n=0:
  - State IDLE; gnt=0; t_c_dat=SEL_IDLE; mux_vld=0; busy=0; beat counter=0.
  - RR pointer=0, so requester 0 has highest priority first.
  - beat_ack=0 and burst_done=0 follow from the registered outputs.
- States:
  - IDLE: no grant.
  - BURST: a grant is active.
- IDLE -> BURST:
  - When req!=0, pick the first set bit searching from ptr, ptr+1, ptr+2 (mod 3).
  - Register gnt (one-hot), t_c_dat = code of the winner, mux_vld=1, busy=1.
  - cnt = max(req_lenX, 1) - 1.
  - ptr = winner+1 mod 3.
  - Latency: req sampled at edge N; grant visible after edge N+1.
- BURST:
  - A beat occurs when mux_vld & mux_rdy.
  - When mux_rdy=0, hold everything: code, cnt, gnt stable.
  - On a non-last beat: cnt decrements.
  - On the last beat (cnt==0 & mux_rdy): burst_done=1.
- Back-to-back handoff on the last beat:
  - If req!=0 at that cycle, arbitrate immediately with the updated pointer, using current req and lengths.
  - The next grant is visible the following cycle; no idle bubble.
  - The same requester may win again only if no other requester is asserting.
  - Otherwise go to IDLE: gnt=0, t_c_dat=SEL_IDLE, mux_vld=0, busy=0.
- Request stability:
  - Deassertion of req mid-burst is ignored; the burst runs to completion.
  - The requester keeps its data valid until its last beat_ack.
  - req_lenX is sampled only at grant; later changes have no effect on the active burst.
- Output invariants:
  - t_c_dat is only ever SEL_IDLE, SEL_K1, SEL_K13 or SEL_K15. It never changes while mux_vld=1 & mux_rdy=0.
  - gnt is one-hot or zero.
  - mux_vld == busy == |gnt.
- Boundary conditions:
  - LEN_W all-ones gives a 2^LEN_W - 1 beat burst; the counter never wraps below 0.
  - len 0 and len 1 are both 1 beat.
- Reset mid-burst aborts immediately. There is no burst_done; the consumer discards the partial burst.

Decomposition:
- Shared package inmux_pkg:
  - select-code constants SEL_IDLE/SEL_K1/SEL_K13/SEL_K15
  - requester index constants
  - state enum {IDLE, BURST}
- One natural sub-module: rr_pick3, a combinational 3-way round-robin picker.
  - Inputs: req[2:0], ptr[1:0].
  - Outputs: one-hot win, win index, any.
  - Instantiated once; reusable by other mux schedulers.

Test Plan:
- Single requester: reset, req=3'b010, req_len1=3, mux_rdy=1 -> one cycle after req, gnt=3'b010, t_c_dat=5, mux_vld=1 for exactly 3 cycles; beat_ack[1] three pulses; burst_done on 3rd beat; then t_c_dat=0, busy=0.
- All requesting, len=1 each, mux_rdy=1 -> t_c_dat sequence 1,5,7,1,5,7 on consecutive cycles with no bubble; each burst_done asserted.
- Backpressure: req=3'b100, len=2, mux_rdy pattern 1,0,0,1 -> t_c_dat=7 held for 4 cycles; beat_ack[2] pulses only in cycles 1 and 4; burst_done in cycle 4.
- Length edge cases:
  - req_len0=0 -> exactly 1 beat.
  - req_len0=255 -> exactly 255 beats then IDLE.
  - req dropped after the first beat -> burst still completes.
- Fairness: req=3'b101 held, len=1 -> grants alternate 1,7,1,7; req[1] raised mid-stream is granted within 2 bursts.
- Reset: reset_n pulled low mid-burst (cnt=5) -> same-instant gnt=0, t_c_dat=0, mux_vld=0, no burst_done; after release with req=3'b111 -> requester 0 granted first.
